// File: rtl/vga_frame_controller.sv
// Programmable-timing VGA frame controller with a per-frame latched palette state.
// Optional macro VGA_BORDER_EN draws a 4-pixel white border around the active region.
module vga_frame_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 8,
  parameter int STATE_W  = 4
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic [STATE_W-1:0] iState,
  output logic               oHS,
  output logic               oVS,
  output logic               oBLANK_n,
  output logic               oFrameStart,
  output logic [10:0]        oX,
  output logic [9:0]         oY,
  output logic [COLOR_W-1:0] r_data,
  output logic [COLOR_W-1:0] g_data,
  output logic [COLOR_W-1:0] b_data
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_LVL = (HS_POL != 0);
  localparam logic VS_LVL = (VS_POL != 0);

  localparam logic [COLOR_W-1:0] C_FULL = '1;
  localparam logic [COLOR_W-1:0] C_HALF = COLOR_W'(1) << (COLOR_W - 1);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [3:0]  state_lo;
  logic [3:0]  frame_state;

  logic               active;
  logic               hs_on;
  logic               vs_on;
  logic [COLOR_W-1:0] level;
  logic [COLOR_W-1:0] r_nxt;
  logic [COLOR_W-1:0] g_nxt;
  logic [COLOR_W-1:0] b_nxt;

  // Palette index is always 4 bits wide; narrow state inputs pad with zeros.
  generate
    if (STATE_W >= 4) begin : g_state_wide
      assign state_lo = iState[3:0];
    end else begin : g_state_narrow
      assign state_lo = {{(4 - STATE_W){1'b0}}, iState};
    end
  endgenerate

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_state <= '0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
      // Latch on the very last pixel so the new colour starts exactly at (0,0).
      if (h_cnt == H_LAST && v_cnt == V_LAST)
        frame_state <= state_lo;
    end
  end

  always_comb begin
    active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_on  = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_on  = (v_cnt >= VS_START) && (v_cnt < VS_END);
    level  = frame_state[3] ? C_HALF : C_FULL;
    r_nxt  = (active && frame_state[0]) ? level : '0;
    g_nxt  = (active && frame_state[1]) ? level : '0;
    b_nxt  = (active && frame_state[2]) ? level : '0;
`ifdef VGA_BORDER_EN
    if (active && ((h_cnt < 11'd4) || (h_cnt >= H_ACT - 11'd4) ||
                   (v_cnt < 10'd4) || (v_cnt >= V_ACT - 10'd4))) begin
      r_nxt = C_FULL;
      g_nxt = C_FULL;
      b_nxt = C_FULL;
    end
`endif
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oHS         <= ~HS_LVL;
      oVS         <= ~VS_LVL;
      oBLANK_n    <= 1'b0;
      oFrameStart <= 1'b0;
      oX          <= '0;
      oY          <= '0;
      r_data      <= '0;
      g_data      <= '0;
      b_data      <= '0;
    end else begin
      oHS         <= hs_on ? HS_LVL : ~HS_LVL;
      oVS         <= vs_on ? VS_LVL : ~VS_LVL;
      oBLANK_n    <= active;
      oFrameStart <= (h_cnt == 11'd0) && (v_cnt == 10'd0);
      oX          <= active ? h_cnt : '0;
      oY          <= active ? v_cnt : '0;
      r_data      <= r_nxt;
      g_data      <= g_nxt;
      b_data      <= b_nxt;
    end
  end

endmodule

// File: tb/tb_vga_frame_controller.sv
// Bench for vga_frame_controller on a reduced 24x7 timing, compared against a
// pixel-index reference model; also aware of VGA_BORDER_EN.
module tb_vga_frame_controller;

  localparam int HA = 16, HFP = 2, HSY = 4, HBP = 2;
  localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;

  logic        clk;
  logic        rst_n;
  logic [3:0]  state;
  logic        hs, vs, blank_n, fstart;
  logic [10:0] ox;
  logic [9:0]  oy;
  logic [7:0]  r, g, b;
  logic [48:0] obs;

  int checks = 0;
  int errors = 0;
  int idx = -1;
  int cyc = 0;
  int last_fs = -1;
  int hs_ones, vs_lows, blank_ones;
  logic [3:0] m_state = 4'h0;

  vga_frame_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1), .VS_POL(0), .COLOR_W(8), .STATE_W(4)
  ) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iState(state),
    .oHS(hs), .oVS(vs), .oBLANK_n(blank_n), .oFrameStart(fstart),
    .oX(ox), .oY(oy), .r_data(r), .g_data(g), .b_data(b)
  );

  assign obs = {hs, vs, blank_n, fstart, ox, oy, r, g, b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for linear pixel index p of the frame sequence.
  function automatic logic [48:0] model(int p, logic [3:0] fs);
    int x, y;
    logic act, e_hs, e_vs;
    logic [7:0] lvl, er, eg, eb;
    x = p % HT;
    y = (p / HT) % VT;
    act = (x < HA) && (y < VA);
    e_hs = (x >= HA + HFP) && (x < HA + HFP + HSY);
    e_vs = !((y >= VA + VFP) && (y < VA + VFP + VSY));
    lvl = fs[3] ? 8'h80 : 8'hFF;
    er = (act && fs[0]) ? lvl : 8'h00;
    eg = (act && fs[1]) ? lvl : 8'h00;
    eb = (act && fs[2]) ? lvl : 8'h00;
`ifdef VGA_BORDER_EN
    if (act && (x < 4 || x >= HA - 4 || y < 4 || y >= VA - 4)) begin
      er = 8'hFF; eg = 8'hFF; eb = 8'hFF;
    end
`endif
    return {e_hs, e_vs, act, (x == 0 && y == 0),
            act ? 11'(x) : 11'd0, act ? 10'(y) : 10'd0, er, eg, eb};
  endfunction

  task automatic check(string tag, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    idx++;
    cyc++;
    @(negedge clk);
    check("pixel", 64'(obs), 64'(model(idx, m_state)));
    hs_ones    += int'(hs);
    vs_lows    += int'(!vs);
    blank_ones += int'(blank_n);
    if (fstart) begin
      if (last_fs >= 0) check("frame_period", 64'(cyc - last_fs), 64'(FRAME));
      last_fs = cyc;
    end
    if (idx % FRAME == FRAME - 1) m_state = state;
  endtask

  task automatic run_to(int target);
    while (idx < target) cycle();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'(obs), 64'({1'b0, 1'b1, 47'd0}));
    repeat (2) @(negedge clk);
    check("reset_hold", 64'(obs), 64'({1'b0, 1'b1, 47'd0}));
    rst_n = 1'b1;
    idx = -1;
    m_state = 4'h0;
    last_fs = -1;
  endtask

  initial begin
    rst_n = 1'b0;
    state = 4'h3;
    repeat (3) @(negedge clk);
    check("reset_state", 64'(obs), 64'({1'b0, 1'b1, 47'd0}));
    rst_n = 1'b1;

    run_to(HT + 5);
`ifndef VGA_BORDER_EN
    check("first_frame_black", 64'({r, g, b}), 64'(24'h000000));
`else
    check("border_pixel", 64'({r, g, b}), 64'(24'hFFFFFF));
`endif
    run_to(FRAME + HT + 5);
`ifndef VGA_BORDER_EN
    check("state3_yellow", 64'({r, g, b}), 64'(24'hFFFF00));
`endif
    state = 4'hC;
    run_to(FRAME + 2 * HT + 2);
`ifndef VGA_BORDER_EN
    check("no_tear", 64'({r, g, b}), 64'(24'hFFFF00));
`endif
    run_to(2 * FRAME + HT + 5);
`ifndef VGA_BORDER_EN
    check("state_c_half_blue", 64'({r, g, b}), 64'(24'h000080));
`endif

    // Line/frame level timing over exactly one frame starting at a frame boundary.
    run_to(3 * FRAME - 1);
    hs_ones = 0; vs_lows = 0; blank_ones = 0;
    run_to(4 * FRAME - 1);
    check("hs_high_per_frame", 64'(hs_ones), 64'(HSY * VT));
    check("vs_low_per_frame", 64'(vs_lows), 64'(VSY * HT));
    check("blank_n_per_frame", 64'(blank_ones), 64'(HA * VA));

    // Random palette changes at arbitrary times.
    for (int i = 0; i < 6 * FRAME; i++) begin
      cycle();
      if ($urandom_range(0, 39) == 0) state = 4'($urandom_range(0, 15));
    end

    // Reset mid-line, then confirm restart at (0,0) with a black first frame.
    run_to(idx + 7 - (idx % HT) + HT);
    state = 4'h7;
    apply_reset();
    cycle();
    check("restart_origin", 64'({fstart, ox, oy}), 64'({1'b1, 11'd0, 10'd0}));
    run_to(HT + 3);
`ifndef VGA_BORDER_EN
    check("post_reset_black", 64'({r, g, b}), 64'(24'h000000));
`endif
    run_to(FRAME + HT + 3);
`ifndef VGA_BORDER_EN
    check("post_reset_white", 64'({r, g, b}), 64'(24'hFFFFFF));
`endif
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle();
      if ($urandom_range(0, 29) == 0) state = 4'($urandom_range(0, 15));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
